// File: rtl/int_arbiter_if.sv
// Bridge register bus and interrupt handshake between the CPU side and int_arbiter.
interface int_arbiter_if #(
  parameter int unsigned N_SRC = 6
);
  logic [31:0]      Addr;
  logic             WE;
  logic [31:0]      Din;
  logic [31:0]      Dout;
  logic [N_SRC-1:0] irq_src;
  logic             int_ack;
  logic             irq_out;
  logic [2:0]       irq_id;

  modport master (
    output Addr, WE, Din, irq_src, int_ack,
    input  Dout, irq_out, irq_id
  );

  modport slave (
    input  Addr, WE, Din, irq_src, int_ack,
    output Dout, irq_out, irq_id
  );
endinterface

// File: rtl/int_arbiter.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, fixed-priority
// arbitration and an assert/ack/EOI handshake toward the CPU's single irq input.
module int_arbiter #(
  parameter int unsigned N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f50
) (
  input logic          clk,
  input logic          reset,
  int_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t           state, state_n;
  logic [N_SRC-1:0] pending, pending_n;
  logic [N_SRC-1:0] mask, mode, src_q;
  logic [N_SRC-1:0] rise, clr, req;
  logic [7:0]       req_ext;
  logic [2:0]       winner;
  logic             irq_out, irq_out_n;
  logic [2:0]       irq_id, irq_id_n;

  logic [31:0] off;
  logic        in_win;
  logic [2:0]  word;
  logic        wr_pend, wr_mask, wr_mode, wr_eoi;
  logic [31:0] dout;
  logic        unused_din;

  // Addresses below BASE_ADDR wrap to large offsets, so one compare bounds the window.
  assign off    = bus.Addr - BASE_ADDR;
  assign in_win = (off <= 32'h13);
  assign word   = off[4:2];

  assign wr_pend = bus.WE && in_win && (word == 3'd0);
  assign wr_mask = bus.WE && in_win && (word == 3'd1);
  assign wr_mode = bus.WE && in_win && (word == 3'd2);
  assign wr_eoi  = bus.WE && in_win && (word == 3'd4);

  assign unused_din = ^bus.Din[31:N_SRC];

  // Edge bits: sticky, set beats W1C. Level bits: follow the source.
  assign rise      = bus.irq_src & ~src_q;
  assign clr       = wr_pend ? bus.Din[N_SRC-1:0] : '0;
  assign pending_n = (mode & ((pending & ~clr) | rise)) | (~mode & bus.irq_src);
  assign req       = pending & mask;

  always_comb begin
    req_ext = '0;
    req_ext[N_SRC-1:0] = req;
    winner = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (req[i-1]) winner = 3'(i - 1);
    end
  end

  always_comb begin
    state_n   = state;
    irq_out_n = irq_out;
    irq_id_n  = irq_id;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n   = ASSERT;
          irq_out_n = 1'b1;
          irq_id_n  = winner;
        end
      end
      ASSERT: begin
        if (bus.int_ack) begin
          state_n   = SERVICE;
          irq_out_n = 1'b0;
        end else if (!req_ext[irq_id]) begin
          state_n   = IDLE;
          irq_out_n = 1'b0;
        end
      end
      SERVICE: begin
        irq_out_n = 1'b0;
        if (wr_eoi) state_n = IDLE;
      end
      default: begin
        state_n   = IDLE;
        irq_out_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      irq_out <= 1'b0;
      irq_id  <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '1;
      src_q   <= '0;
    end else begin
      state   <= state_n;
      irq_out <= irq_out_n;
      irq_id  <= irq_id_n;
      pending <= pending_n;
      src_q   <= bus.irq_src;
      if (wr_mask) mask <= bus.Din[N_SRC-1:0];
      if (wr_mode) mode <= bus.Din[N_SRC-1:0];
    end
  end

  always_comb begin
    dout = '0;
    if (in_win) begin
      case (word)
        3'd0:    dout = {{(32-N_SRC){1'b0}}, pending};
        3'd1:    dout = {{(32-N_SRC){1'b0}}, mask};
        3'd2:    dout = {{(32-N_SRC){1'b0}}, mode};
        3'd3:    dout = {(state == SERVICE), 28'd0, irq_id};
        default: dout = '0;
      endcase
    end
  end

  assign bus.Dout    = dout;
  assign bus.irq_out = irq_out;
  assign bus.irq_id  = irq_id;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: register access, edge/level capture, arbitration,
// handshake corner cases and asynchronous reset.
module tb_int_arbiter;

  localparam logic [31:0] A_PEND = 32'h7f50;
  localparam logic [31:0] A_MASK = 32'h7f54;
  localparam logic [31:0] A_MODE = 32'h7f58;
  localparam logic [31:0] A_ID   = 32'h7f5c;
  localparam logic [31:0] A_EOI  = 32'h7f60;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] d;

  int_arbiter_if #(.N_SRC(6)) bus ();

  int_arbiter #(.N_SRC(6), .BASE_ADDR(32'h0000_7f50)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed normally");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.Addr = a;
    bus.Din  = v;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
    bus.Addr = '0;
    bus.Din  = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.Addr = a;
    bus.WE   = 1'b0;
    #1;
    v = bus.Dout;
    bus.Addr = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rd(A_PEND, d); chk("reset PEND", d, 32'h0);
    rd(A_MASK, d); chk("reset MASK", d, 32'h0);
    rd(A_MODE, d); chk("reset MODE", d, 32'h3f);
    rd(A_ID, d);   chk("reset ID", d, 32'h0);
    checks++;
    if (bus.irq_out !== 1'b0) begin
      errors++;
      $display("FAIL reset irq_out: got %b expected 0", bus.irq_out);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_edge_latency();
    wr(A_MASK, 32'h3f);
    bus.irq_src = 6'h04;
    tick();
    bus.irq_src = 6'h00;
    chk("latency irq_out at t+1", {31'd0, bus.irq_out}, 32'h0);
    rd(A_PEND, d); chk("latency PEND at t+1", d, 32'h04);
    tick();
    chk("latency irq_out at t+2", {31'd0, bus.irq_out}, 32'h1);
    chk("latency irq_id at t+2", {29'd0, bus.irq_id}, 32'h2);
    rd(A_ID, d); chk("latency ID assert", d, 32'h2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("ack irq_out", {31'd0, bus.irq_out}, 32'h0);
    rd(A_ID, d); chk("ack ID service", d, 32'h8000_0002);
    wr(A_PEND, 32'h04);
    rd(A_PEND, d); chk("W1C PEND", d, 32'h0);
    wr(A_EOI, 32'h0);
    rd(A_ID, d); chk("EOI ID idle", d, 32'h2);
    tick();
    chk("idle stays low", {31'd0, bus.irq_out}, 32'h0);
  endtask

  task automatic test_priority();
    bus.irq_src = 6'h12;
    tick();
    bus.irq_src = 6'h00;
    tick();
    chk("prio irq_out", {31'd0, bus.irq_out}, 32'h1);
    chk("prio irq_id", {29'd0, bus.irq_id}, 32'h1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    wr(A_PEND, 32'h02);
    rd(A_PEND, d); chk("prio PEND after W1C", d, 32'h10);
    wr(A_EOI, 32'h0);
    chk("prio no reassert on EOI edge", {31'd0, bus.irq_out}, 32'h0);
    rd(A_ID, d); chk("prio ID idle", d, 32'h1);
    tick();
    chk("prio reassert irq_out", {31'd0, bus.irq_out}, 32'h1);
    chk("prio reassert irq_id", {29'd0, bus.irq_id}, 32'h4);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    wr(A_PEND, 32'h10);
    wr(A_EOI, 32'h0);
  endtask

  task automatic test_mask_drop();
    bus.irq_src = 6'h08;
    tick();
    bus.irq_src = 6'h00;
    tick();
    chk("mask assert id", {29'd0, bus.irq_id}, 32'h3);
    wr(A_MASK, 32'h37);
    tick();
    chk("mask drop irq_out", {31'd0, bus.irq_out}, 32'h0);
    rd(A_ID, d); chk("mask drop not service", d & 32'h8000_0000, 32'h0);
    tick();
    chk("mask stays low", {31'd0, bus.irq_out}, 32'h0);
    wr(A_MASK, 32'h3f);
    tick();
    chk("unmask irq_out", {31'd0, bus.irq_out}, 32'h1);
    chk("unmask irq_id", {29'd0, bus.irq_id}, 32'h3);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    wr(A_PEND, 32'h08);
    wr(A_EOI, 32'h0);
  endtask

  task automatic test_level();
    wr(A_MASK, 32'h00);
    wr(A_MODE, 32'h00);
    bus.irq_src = 6'h01;
    tick();
    rd(A_PEND, d); chk("level held", d, 32'h01);
    wr(A_PEND, 32'h01);
    rd(A_PEND, d); chk("level W1C ignored", d, 32'h01);
    bus.irq_src = 6'h00;
    tick();
    rd(A_PEND, d); chk("level released", d, 32'h00);
    wr(A_MODE, 32'h3f);
  endtask

  task automatic test_set_wins();
    bus.irq_src = 6'h20;
    tick();
    bus.irq_src = 6'h00;
    tick();
    rd(A_PEND, d); chk("edge bit5 set", d, 32'h20);
    bus.irq_src = 6'h20;
    wr(A_PEND, 32'h20);
    bus.irq_src = 6'h00;
    rd(A_PEND, d); chk("set beats W1C", d, 32'h20);
    tick();
    wr(A_PEND, 32'h20);
    rd(A_PEND, d); chk("W1C alone clears", d, 32'h00);
  endtask

  task automatic test_back_to_back();
    wr(A_MASK, 32'h3f);
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = 6'h00;
    tick();
    chk("b2b assert id", {29'd0, bus.irq_id}, 32'h0);
    chk("b2b assert irq_out", {31'd0, bus.irq_out}, 32'h1);
    bus.int_ack = 1'b1;
    wr(A_EOI, 32'h0);
    bus.int_ack = 1'b0;
    rd(A_ID, d); chk("ack+EOI lands in service", d, 32'h8000_0000);
    wr(A_PEND, 32'h01);
    wr(A_EOI, 32'h0);
    rd(A_ID, d); chk("b2b back to idle", d, 32'h0);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    rd(A_ID, d); chk("ack in idle ignored", d, 32'h0);
    wr(A_EOI, 32'h0);
    chk("EOI in idle ignored", {31'd0, bus.irq_out}, 32'h0);
  endtask

  task automatic test_async_reset();
    wr(A_MODE, 32'h15);
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = 6'h00;
    tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    rd(A_ID, d); chk("pre-reset service", d, 32'h8000_0000);
    #2 reset = 1'b1;
    #1;
    chk("async irq_out", {31'd0, bus.irq_out}, 32'h0);
    rd(A_MASK, d); chk("async MASK", d, 32'h0);
    rd(A_MODE, d); chk("async MODE", d, 32'h3f);
    rd(A_PEND, d); chk("async PEND", d, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    wr(A_MASK, 32'h2a);
    wr(32'h7f40, 32'hffff_ffff);
    wr(32'h7f64, 32'hffff_ffff);
    rd(A_MASK, d); chk("outside MASK", d, 32'h2a);
    rd(A_MODE, d); chk("outside MODE", d, 32'h3f);
    rd(A_PEND, d); chk("outside PEND", d, 32'h0);
    rd(32'h7f40, d); chk("outside read", d, 32'h0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.Addr    = '0;
    bus.WE      = 1'b0;
    bus.Din     = '0;
    bus.irq_src = '0;
    bus.int_ack = 1'b0;
    #1;
    test_reset();
    test_edge_latency();
    test_priority();
    test_mask_drop();
    test_level();
    test_set_wins();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
